// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC generator and small fetch queue in front of decode.
// The PC drives a combinational instruction memory. The returned word is
// captured together with its PC in a circular queue. Decode drains the queue
// over a valid/ready handshake. A redirect flushes everything and reloads
// the PC. A stall freezes fetch but lets the queue drain.

`ifndef INSTR_MEM_WIDTH
`define INSTR_MEM_WIDTH 16
`endif

`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif

module instr_fetch_unit #(
    parameter int                  PC_WIDTH   = 64,
    parameter int                  ADDR_WIDTH = `INSTR_MEM_WIDTH,
    parameter int                  IW         = `INSTR_WIDTH,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = '0,
    parameter int                  FQ_DEPTH   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] instr_addr,
    output logic                  re,
    input  logic [IW-1:0]         instr,
    input  logic                  fetch_stall,
    input  logic                  redirect_valid,
    input  logic [PC_WIDTH-1:0]   redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [IW-1:0]         out_instr,
    output logic [PC_WIDTH-1:0]   out_pc
);

    localparam int PTR_W = $clog2(FQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PC_WIDTH-1:0] r_pc;
    logic [PC_WIDTH-1:0] r_qPc    [FQ_DEPTH];
    logic [IW-1:0]       r_qInstr [FQ_DEPTH];
    logic [PTR_W-1:0]    r_head;
    logic [PTR_W-1:0]    r_tail;
    logic [CNT_W-1:0]    r_count;

    logic                w_empty;
    logic                w_full;
    logic                w_enq;
    logic                w_deq;
    logic [PC_WIDTH-1:0] w_redirTarget;

    // Queue status, handshake qualifiers and the word-aligned redirect target.
    // Masking with ~3 keeps the redirect target word-aligned.
    // The enqueue decision depends only on occupancy, never on out_ready.
    always_comb begin
        w_empty       = (r_count == '0);
        w_full        = (r_count == CNT_W'(FQ_DEPTH));
        w_redirTarget = redirect_pc & ~PC_WIDTH'(3);
        w_enq         = rst_n & ~redirect_valid & ~fetch_stall & ~w_full;
        w_deq         = ~w_empty & ~redirect_valid & out_ready;
    end

    // Outputs toward the instruction memory and decode.
    // The head fields read as zero whenever the queue is empty.
    always_comb begin
        instr_addr = r_pc[ADDR_WIDTH-1:0];
        re         = w_enq;
        out_valid  = ~w_empty & ~redirect_valid;
        out_pc     = w_empty ? '0 : r_qPc[r_head];
        out_instr  = w_empty ? '0 : r_qInstr[r_head];
    end

    // Program counter: reload on redirect, advance by one word on each fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc <= w_redirTarget;
        end else if (w_enq) begin
            r_pc <= r_pc + PC_WIDTH'(4);
        end
    end

    // Queue storage: capture {pc, instr} at the tail on every fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FQ_DEPTH; i++) begin
                r_qPc[i]    <= '0;
                r_qInstr[i] <= '0;
            end
        end else if (w_enq) begin
            r_qPc[r_tail]    <= r_pc;
            r_qInstr[r_tail] <= instr;
        end
    end

    // Head, tail and occupancy. A redirect flushes the queue and overrides any handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (redirect_valid) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_deq) begin
                r_head <= r_head + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_enq) - CNT_W'(w_deq);
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed vectors, hand-written corner sequences and a
// randomized run against a queue-based reference model of the fetch unit.

module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [15:0] instr_addr;
    logic        re;
    logic [31:0] instr;
    logic        fetch_stall;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_pc;

    int nCompared = 0;
    int nFailed   = 0;

    typedef struct {
        logic        redir;
        logic [63:0] redirPc;
        logic        stall;
        logic        ready;
        logic        expRe;
        logic        expValid;
        logic [15:0] expAddr;
        logic [63:0] expPc;
        logic [31:0] expInstr;
    } vec_t;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] ins;
    } ent_t;

    vec_t        vecs[$];
    ent_t        modelQ[$];
    logic [63:0] modelPc;

    instr_fetch_unit #(
        .PC_WIDTH   (64),
        .ADDR_WIDTH (16),
        .IW         (32),
        .RESET_PC   (64'h0),
        .FQ_DEPTH   (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .instr_addr     (instr_addr),
        .re             (re),
        .instr          (instr),
        .fetch_stall    (fetch_stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
    );

    // Memory contents: word at byte address a is ((a/4)+1)*0x11, so 0,4,8 give 0x11,0x22,0x33.
    function automatic logic [31:0] memWord(input logic [15:0] a);
        logic [31:0] idx;
        idx = (32'(a) >> 2) + 32'd1;
        return idx * 32'h11;
    endfunction

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational instruction memory.
    always_comb instr = memWord(instr_addr);

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCompared++;
        if (act !== exp) begin
            nFailed++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic redir, input logic [63:0] rpc,
                                 input logic stall, input logic ready);
        redirect_valid = redir;
        redirect_pc    = rpc;
        fetch_stall    = stall;
        out_ready      = ready;
    endtask

    // Compare all outputs at the negedge, then advance to just after the next posedge.
    task automatic cycleCheck(input string tag, input logic eRe, input logic eValid,
                              input logic [15:0] eAddr, input logic [63:0] ePc,
                              input logic [31:0] eInstr);
        @(negedge clk);
        checkOutput({tag, " re"}, 64'(re), 64'(eRe));
        checkOutput({tag, " out_valid"}, 64'(out_valid), 64'(eValid));
        checkOutput({tag, " instr_addr"}, 64'(instr_addr), 64'(eAddr));
        checkOutput({tag, " out_pc"}, out_pc, ePc);
        checkOutput({tag, " out_instr"}, 64'(out_instr), 64'(eInstr));
        @(posedge clk);
        #1;
    endtask

    // Hold reset across one edge, check the reset state, then release just after a posedge.
    task automatic doReset(input string tag);
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        checkOutput({tag, " rst re"}, 64'(re), 64'h0);
        checkOutput({tag, " rst out_valid"}, 64'(out_valid), 64'h0);
        checkOutput({tag, " rst out_pc"}, out_pc, 64'h0);
        checkOutput({tag, " rst out_instr"}, 64'(out_instr), 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        modelQ.delete();
        modelPc = 64'h0;
    endtask

    // One cycle of the reference model: predict outputs from queue contents, compare, then update.
    task automatic modelCycle(input int cyc);
        logic        eRe;
        logic        eValid;
        logic [63:0] ePc;
        logic [31:0] eIns;
        string       tag;
        eRe    = !redirect_valid && !fetch_stall && (modelQ.size() < 2);
        eValid = (modelQ.size() != 0) && !redirect_valid;
        ePc    = (modelQ.size() != 0) ? modelQ[0].pc : 64'h0;
        eIns   = (modelQ.size() != 0) ? modelQ[0].ins : 32'h0;
        tag    = $sformatf("rnd%0d", cyc);
        cycleCheck(tag, eRe, eValid, modelPc[15:0], ePc, eIns);
        if (redirect_valid) begin
            modelQ.delete();
            modelPc = redirect_pc & ~64'd3;
        end else begin
            if (eValid && out_ready) begin
                void'(modelQ.pop_front());
            end
            if (eRe) begin
                modelQ.push_back('{modelPc, memWord(modelPc[15:0])});
                modelPc = modelPc + 64'd4;
            end
        end
    endtask

    // Main test sequence.
    initial begin
        logic [63:0] rpc;
        rst_n = 1'b1;
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b0);

        // Streaming with out_ready=1 from reset.
        vecs.push_back('{1'b0, 64'h0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 64'h0, 32'h00});
        vecs.push_back('{1'b0, 64'h0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0004, 64'h0, 32'h11});
        vecs.push_back('{1'b0, 64'h0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0008, 64'h4, 32'h22});
        vecs.push_back('{1'b0, 64'h0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h000C, 64'h8, 32'h33});
        doReset("t1");
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].redir, vecs[i].redirPc, vecs[i].stall, vecs[i].ready);
            cycleCheck($sformatf("t1v%0d", i), vecs[i].expRe, vecs[i].expValid,
                       vecs[i].expAddr, vecs[i].expPc, vecs[i].expInstr);
        end

        // Backpressure from reset: fill to two entries, hold, then drain.
        vecs.delete();
        vecs.push_back('{1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 64'h0, 32'h00});
        vecs.push_back('{1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0004, 64'h0, 32'h11});
        vecs.push_back('{1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0008, 64'h0, 32'h11});
        vecs.push_back('{1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0008, 64'h0, 32'h11});
        vecs.push_back('{1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0008, 64'h0, 32'h11});
        vecs.push_back('{1'b0, 64'h0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0008, 64'h4, 32'h22});
        vecs.push_back('{1'b0, 64'h0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h000C, 64'h8, 32'h33});
        doReset("t2");
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].redir, vecs[i].redirPc, vecs[i].stall, vecs[i].ready);
            cycleCheck($sformatf("t2v%0d", i), vecs[i].expRe, vecs[i].expValid,
                       vecs[i].expAddr, vecs[i].expPc, vecs[i].expInstr);
        end

        // Redirect with two entries queued: flushed, target fetched, then presented.
        doReset("t3");
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b0);
        cycleCheck("t3a", 1'b1, 1'b0, 16'h0000, 64'h0, 32'h0);
        cycleCheck("t3b", 1'b1, 1'b1, 16'h0004, 64'h0, 32'h11);
        applyStimulus(1'b1, 64'h103, 1'b0, 1'b1);
        cycleCheck("t3c", 1'b0, 1'b0, 16'h0008, 64'h0, 32'h11);
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b1);
        cycleCheck("t3d", 1'b1, 1'b0, 16'h0100, 64'h0, 32'h0);
        cycleCheck("t3e", 1'b1, 1'b1, 16'h0104, 64'h100, 32'h451);
        cycleCheck("t3f", 1'b1, 1'b1, 16'h0108, 64'h104, 32'h462);

        // Stall for three cycles with one entry queued: it drains, pc holds, fetch resumes.
        doReset("t4");
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b0);
        cycleCheck("t4a", 1'b1, 1'b0, 16'h0000, 64'h0, 32'h0);
        applyStimulus(1'b0, 64'h0, 1'b1, 1'b1);
        cycleCheck("t4b", 1'b0, 1'b1, 16'h0004, 64'h0, 32'h11);
        cycleCheck("t4c", 1'b0, 1'b0, 16'h0004, 64'h0, 32'h0);
        cycleCheck("t4d", 1'b0, 1'b0, 16'h0004, 64'h0, 32'h0);
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b1);
        cycleCheck("t4e", 1'b1, 1'b0, 16'h0004, 64'h0, 32'h0);
        cycleCheck("t4f", 1'b1, 1'b1, 16'h0008, 64'h4, 32'h22);

        // Redirect together with stall: redirect is taken, fetch waits for the stall to drop.
        doReset("t5");
        applyStimulus(1'b1, 64'h200, 1'b1, 1'b1);
        cycleCheck("t5a", 1'b0, 1'b0, 16'h0000, 64'h0, 32'h0);
        applyStimulus(1'b0, 64'h0, 1'b1, 1'b1);
        cycleCheck("t5b", 1'b0, 1'b0, 16'h0200, 64'h0, 32'h0);
        cycleCheck("t5c", 1'b0, 1'b0, 16'h0200, 64'h0, 32'h0);
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b1);
        cycleCheck("t5d", 1'b1, 1'b0, 16'h0200, 64'h0, 32'h0);
        cycleCheck("t5e", 1'b1, 1'b1, 16'h0204, 64'h200, 32'h891);

        // Asynchronous reset mid-stream with one entry queued.
        doReset("t6");
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b0);
        cycleCheck("t6a", 1'b1, 1'b0, 16'h0000, 64'h0, 32'h0);
        rst_n = 1'b0;
        #1;
        checkOutput("t6 async out_valid", 64'(out_valid), 64'h0);
        checkOutput("t6 async re", 64'(re), 64'h0);
        checkOutput("t6 async out_pc", out_pc, 64'h0);
        checkOutput("t6 async instr_addr", 64'(instr_addr), 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b1);
        cycleCheck("t6b", 1'b1, 1'b0, 16'h0000, 64'h0, 32'h0);
        cycleCheck("t6c", 1'b1, 1'b1, 16'h0004, 64'h0, 32'h11);

        // Randomized traffic against the reference model, including PC wrap near 2^64.
        doReset("rnd");
        for (int c = 0; c < 600; c++) begin
            rpc = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) begin
                rpc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
            end
            applyStimulus($urandom_range(0, 7) == 0, rpc,
                          $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
            modelCycle(c);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
        $finish;
    end

endmodule
